// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg                                                           |
// | Shared op codes, FSM encoding and default width for the HI/LO        |
// | multiply/divide sequencer.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step                                                          |
// | One radix-2 iteration: add-shift (multiply) or restoring             |
// | subtract-compare (divide), selected by is_div.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] w_operand_ext;
    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    always_comb begin
        w_operand_ext = {1'b0, operand};

        // Multiply: acc_hi[WIDTH] is always clear, so the sum never overflows WIDTH+1 bits.
        w_addend = acc_lo[0] ? w_operand_ext : '0;
        w_sum    = acc_hi + w_addend;

        w_shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        w_ge      = (w_shifted >= w_operand_ext);
        w_diff    = w_shifted - w_operand_ext;

        if (is_div) begin
            nxt_hi = w_ge ? w_diff : w_shifted;
            nxt_lo = {acc_lo[WIDTH-2:0], w_ge};
        end else begin
            nxt_hi = {1'b0, w_sum[WIDTH:1]};
            nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq                                                           |
// | Multi-cycle mult/multu/div/divu sequencer driving the HI/LO pair;    |
// | stalls the pipeline while iterating one bit per cycle.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH:0]   r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_operand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dz;

    logic             w_signed_in;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic             w_signed_op;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_signed_in = ~op[0];
    assign w_a_mag     = (w_signed_in && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (w_signed_in && b[WIDTH-1]) ? -b : b;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (r_op[1]),
        .acc_hi  (r_acc_hi),
        .acc_lo  (r_acc_lo),
        .operand (r_operand),
        .nxt_hi  (w_step_hi),
        .nxt_lo  (w_step_lo)
    );

    // Sign fix-up. For divide-by-zero the remainder equals |a|, so the normal
    // dividend-sign correction restores the raw a for hi.
    always_comb begin
        w_signed_op = ~r_op[0];
        w_prod      = {r_acc_hi[WIDTH-1:0], r_acc_lo};
        w_rem       = r_acc_hi[WIDTH-1:0];
        if (!r_op[1]) begin
            if (w_signed_op && r_sign_q) begin
                w_prod = -w_prod;
            end
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else begin
            if (r_div0) begin
                w_res_lo = '1;
            end else if (w_signed_op && r_sign_q) begin
                w_res_lo = -r_acc_lo;
            end else begin
                w_res_lo = r_acc_lo;
            end
            w_res_hi = (w_signed_op && r_sign_r) ? -w_rem : w_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MULT;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dz      <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_op      <= op;
                        r_acc_hi  <= '0;
                        // Divide iterates on the dividend; multiply shifts the multiplier out.
                        r_acc_lo  <= op[1] ? w_a_mag : w_b_mag;
                        r_operand <= op[1] ? w_b_mag : w_a_mag;
                        r_sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r  <= a[WIDTH-1];
                        r_div0    <= op[1] && (b == '0);
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_state   <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_dz    <= r_div0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == ST_CALC) || (r_state == ST_SIGN);
    assign done    = (r_state == ST_DONE);
    assign hilo_we = done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign dz      = r_dz;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_seq                                                        |
// | Self-checking bench for muldiv_seq against an arithmetic model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          done;
    logic          hilo_we;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          dz;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hilo_we (hilo_we),
        .hi      (hi),
        .lo      (lo),
        .dz      (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo, dz} from plain integer arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] rh, rl;
        logic        z;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        z  = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            OP_MULT: begin
                p  = 64'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, x} * {32'd0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = x;
                    z  = 1'b1;
                end else if (o == OP_DIV) begin
                    q  = sx / sy;
                    r  = sx % sy;
                    rl = 32'(q);
                    rh = 32'(r);
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
        return {rh, rl, z};
    endfunction

    // Called at a negedge; start is presented for one edge (E0). Returns at the
    // negedge where done is seen, with lat = edges after E0 and busy cycle count.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [64:0] res, output int lat, output int busy_n, output logic we);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        res = {hi, lo, dz};
        we  = hilo_we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, hilo_we, hi, lo, dz} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b hi=%h lo=%h dz=%b, want all 0",
                     busy, done, hilo_we, hi, lo, dz);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_multu_max();
        logic [64:0] res;
        int lat, bn;
        logic we;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bn, we);
        n_checks++;
        if (res !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL multu_max_result: got %h want %h", res, {32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL multu_latency: got %0d edges want %0d", lat, LAT);
        end
        n_checks++;
        if (bn !== LAT) begin
            n_fail++;
            $display("FAIL multu_busy_cycles: got %0d want %0d", bn, LAT);
        end
        n_checks++;
        if (we !== 1'b1) begin
            n_fail++;
            $display("FAIL multu_hilo_we: got %b want 1", we);
        end
        @(negedge clk);
        n_checks++;
        if ({done, hilo_we, busy, hi, lo} !== {3'b000, 32'hFFFF_FFFE, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL multu_pulse_hold: got done=%b we=%b busy=%b hi=%h lo=%h", done, hilo_we, busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] res;
        int lat, bn;
        logic we;
        @(negedge clk);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, res, lat, bn, we);
        n_checks++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
            n_fail++;
            $display("FAIL mult_neg3x7: got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        end
        run_op(OP_DIVU, 32'd7, 32'd2, res, lat, bn, we);
        n_checks++;
        if (res !== {32'd1, 32'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL divu_b2b_result: got %h want %h", res, {32'd1, 32'd3, 1'b0});
        end
        n_checks++;
        if (lat !== LAT || bn !== LAT) begin
            n_fail++;
            $display("FAIL divu_b2b_timing: got lat=%0d busy=%0d want %0d %0d", lat, bn, LAT, LAT);
        end
    endtask

    task automatic test_div_signed();
        logic [64:0] res;
        int lat, bn;
        logic we;
        @(negedge clk);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bn, we);
        n_checks++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
            n_fail++;
            $display("FAIL div_neg7_by2: got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        end
        @(negedge clk);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bn, we);
        n_checks++;
        if (res !== {32'd0, 32'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL div_overflow: got %h want %h", res, {32'd0, 32'h8000_0000, 1'b0});
        end
    endtask

    task automatic test_div_by_zero();
        logic [64:0] res;
        int lat, bn;
        logic we;
        @(negedge clk);
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, res, lat, bn, we);
        n_checks++;
        if (res !== {32'h0000_1234, 32'hFFFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL divu_by_zero: got %h want %h", res, {32'h0000_1234, 32'hFFFF_FFFF, 1'b1});
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d want %0d", lat, LAT);
        end
        @(negedge clk);
        run_op(OP_MULT, 32'd2, 32'd3, res, lat, bn, we);
        n_checks++;
        if (res !== {32'd0, 32'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL mult_after_div0: got %h want %h", res, {32'd0, 32'd6, 1'b0});
        end
    endtask

    task automatic test_flush();
        logic [64:0] hold;
        bit          seen;
        @(negedge clk);
        hold  = {hi, lo, dz};
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'h0000_1111;
        b     = 32'h0000_2222;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got %b want 0", busy);
        end
        seen = 1'b0;
        repeat (50) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_activity: got busy/done activity=%b want 0", seen);
        end
        n_checks++;
        if ({hi, lo, dz} !== hold) begin
            n_fail++;
            $display("FAIL flush_hold: got %h want %h", {hi, lo, dz}, hold);
        end
    endtask

    task automatic test_async_reset();
        logic [64:0] res;
        int lat, bn;
        logic we;
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0003;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, hilo_we, hi, lo, dz} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b we=%b hi=%h lo=%h dz=%b, want all 0",
                     busy, done, hilo_we, hi, lo, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        end
        run_op(OP_MULT, 32'd5, 32'd5, res, lat, bn, we);
        n_checks++;
        if (res !== {32'd0, 32'd25, 1'b0} || lat !== LAT) begin
            n_fail++;
            $display("FAIL mult_5x5_after_reset: got %h lat=%0d want %h lat=%0d",
                     res, lat, {32'd0, 32'd25, 1'b0}, LAT);
        end
    endtask

    task automatic test_random();
        logic [64:0] res, exp;
        logic [1:0]  o;
        logic [31:0] x, y;
        int lat, bn;
        logic we;
        @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            o = 2'($urandom);
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = -32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
            exp = ref_model(o, x, y);
            run_op(o, x, y, res, lat, bn, we);
            n_checks++;
            if (res !== exp || lat !== LAT) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d want %h lat=%0d",
                         i, o, x, y, res, lat, exp, LAT);
            end
            // Alternate between back-to-back and one idle cycle between ops.
            if (i % 2 == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_multu_max();
        test_back_to_back();
        test_div_signed();
        test_div_by_zero();
        test_flush();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire
